// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC128S conversion interface.
package a2d_pkg;

  typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;

  localparam logic [1:0]  CMD_PAD_HI = 2'b00;
  localparam logic [10:0] CMD_PAD_LO = 11'h000;
  localparam int          XFER_BITS  = 16;

  function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
    return {CMD_PAD_HI, ch, CMD_PAD_LO};
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master: SCLK idles high, MOSI shifts on falls, MISO sampled just before rises.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  localparam int BW = $clog2(XFER_BITS + 1);
  localparam logic [SCLK_DIV_W-1:0] CNT_PRE  = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
  localparam logic [SCLK_DIV_W-1:0] CNT_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] CNT_FALL = '1;

  logic [SCLK_DIV_W-1:0] cnt_q;
  logic [15:0]           shft_q;
  logic                  smpl_q;
  logic                  ss_n_q;
  logic [BW-1:0]         bits_q;

  assign SCLK    = cnt_q[SCLK_DIV_W-1];
  assign MOSI    = shft_q[15];
  assign SS_n    = ss_n_q;
  assign rd_data = {shft_q[14:0], smpl_q};
  // Last pending fall after the 16th rise: final shift, SCLK held high, SS_n released.
  assign done    = !ss_n_q && (cnt_q == CNT_FALL) && (bits_q == BW'(XFER_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q <= 1'b1;
      cnt_q  <= CNT_PRE;
      shft_q <= '0;
      smpl_q <= 1'b0;
      bits_q <= '0;
    end else if (wrt) begin
      ss_n_q <= 1'b0;
      cnt_q  <= CNT_PRE;
      shft_q <= cmd;
      bits_q <= '0;
    end else if (!ss_n_q) begin
      if (done) begin
        shft_q <= rd_data;
        ss_n_q <= 1'b1;
        cnt_q  <= CNT_PRE;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_RISE) begin
          smpl_q <= MISO;
          bits_q <= bits_q + 1'b1;
        end
        // The first fall precedes any sample, so it leaves the shifter alone.
        if (cnt_q == CNT_FALL && bits_q != '0)
          shft_q <= rd_data;
      end
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// ADC128S conversion sequencer: command transfer, SS_n gap, then result transfer.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5,
  parameter int GAP_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        state_q;
  logic [2:0]    chnl_q;
  logic [GW-1:0] gap_q;
  logic [11:0]   res_q;
  logic          cmplt_q;

  logic        accept, gap_end, wrt, done;
  logic [15:0] cmd, rd_data;
  logic        rd_unused;

  assign accept  = strt_cnv && (state_q == IDLE || state_q == DONE);
  assign gap_end = (state_q == GAP) && (gap_q == '0);
  assign wrt     = accept || gap_end;
  // Use the live channel on the accepting edge; the latch only lands afterwards.
  assign cmd     = mk_cmd(accept ? chnnl : chnl_q);

  assign cnv_cmplt = cmplt_q;
  assign res       = res_q;
  assign rd_unused = ^rd_data[15:12];

  spi_mstr16 #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (MISO),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chnl_q  <= '0;
      gap_q   <= '0;
      res_q   <= '0;
      cmplt_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: if (strt_cnv) begin
          state_q <= TX1;
          chnl_q  <= chnnl;
          cmplt_q <= 1'b0;
        end
        TX1: if (done) begin
          state_q <= GAP;
          gap_q   <= GW'(GAP_CYCLES - 1);
        end
        GAP: if (gap_q == '0) state_q <= TX2;
             else             gap_q   <= gap_q - 1'b1;
        TX2: if (done) begin
          state_q <= DONE;
          res_q   <= rd_data[11:0];
          cmplt_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed/randomized bench for a2d_intf with a behavioural ADC128S slave and SPI protocol monitor.
module tb_a2d_intf;

  localparam int LAT     = 528 + 32 + 528;
  localparam int XFER_LO = 528;
  localparam int GAP     = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n, SCLK, MOSI;
  logic        MISO = 1'b0;

  int tests = 0;
  int fails = 0;

  a2d_intf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ADC model: each frame returns the conversion for the channel addressed in the previous frame.
  typedef struct {
    int          rises;
    int          falls;
    int          low;
    int          gap;
    logic [15:0] mosi;
  } win_t;

  logic [11:0] mem [8];
  logic [3:0]  nib = 4'h0;
  logic [2:0]  last_ch = 3'd0;
  logic [15:0] reply = 16'h0;
  win_t        win_q[$];
  win_t        cur;
  logic        in_win = 1'b0;
  logic        ss_p = 1'b1, sc_p = 1'b1;
  int          t_fall = 0, t_rise = 0, bidx = 0, edge_hi = 0;

  always @(SS_n or SCLK or rst_n) begin
    if (rst_n !== 1'b1) begin
      in_win = 1'b0;
    end else begin
      if (ss_p === 1'b1 && SS_n === 1'b0) begin
        in_win = 1'b1;
        cur    = '{0, 0, 0, cyc - t_rise, 16'h0};
        t_fall = cyc;
        bidx   = 0;
        reply  = {nib, mem[last_ch]};
        MISO   = reply[15];
      end else if (ss_p === 1'b0 && SS_n === 1'b1 && in_win) begin
        cur.low = cyc - t_fall;
        t_rise  = cyc;
        win_q.push_back(cur);
        last_ch = cur.mosi[13:11];
        in_win  = 1'b0;
      end
      if (SCLK !== sc_p) begin
        if (SS_n !== 1'b0) edge_hi++;
        else if (SCLK === 1'b1) begin
          cur.rises++;
          cur.mosi = {cur.mosi[14:0], MOSI};
          bidx++;
          if (bidx < 16) MISO = reply[15 - bidx];
        end else cur.falls++;
      end
    end
    ss_p = SS_n;
    sc_p = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [11:0] prev_res = 12'h0;

  task automatic run_conv(input int ch, input int intr_at, input int intr_ch, input int rst_at);
    int   lat;
    bit   aborted, res_chg;
    win_t w;
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl    = 3'(ch);
    @(negedge clk);
    strt_cnv = 1'b0;
    chk("cmplt_clr", 32'(cnv_cmplt), 32'd0);
    lat = 0; aborted = 0; res_chg = 0;
    while (cnv_cmplt !== 1'b1 && lat < 3000) begin
      chnnl = 3'($urandom);
      if (res !== prev_res) res_chg = 1;
      if (lat == intr_at) begin
        strt_cnv = 1'b1;
        chnnl    = 3'(intr_ch);
      end
      if (lat == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ss_n",  32'(SS_n),      32'd1);
        chk("rst_sclk",  32'(SCLK),      32'd1);
        chk("rst_mosi",  32'(MOSI),      32'd0);
        chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("rst_res",   32'(res),       32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        aborted  = 1;
        prev_res = 12'h0;
        win_q.delete();
        break;
      end
      @(negedge clk);
      strt_cnv = 1'b0;
      lat++;
    end
    if (!aborted) begin
      chk("latency",    32'(lat),     32'(LAT));
      chk("res",        32'(res),     32'(mem[ch]));
      chk("res_stable", 32'(res_chg), 32'd0);
      chk("n_windows",  32'(win_q.size()), 32'd2);
      for (int i = 0; i < 2 && win_q.size() > 0; i++) begin
        w = win_q.pop_front();
        chk("sclk_rises", 32'(w.rises), 32'd16);
        chk("sclk_falls", 32'(w.falls), 32'd16);
        chk("ss_low_clk", 32'(w.low),   32'(XFER_LO));
        chk("mosi_cmd",   32'(w.mosi),  32'(ch) << 11);
        if (i == 1) chk("gap_clk", 32'(w.gap), 32'(GAP));
      end
      win_q.delete();
      prev_res = res;
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 12'($urandom);
    rst_n    = 1'b0;
    strt_cnv = 1'b0;
    chnnl    = 3'd0;
    repeat (3) @(negedge clk);
    chk("init_ss_n",  32'(SS_n),      32'd1);
    chk("init_sclk",  32'(SCLK),      32'd1);
    chk("init_mosi",  32'(MOSI),      32'd0);
    chk("init_cmplt", 32'(cnv_cmplt), 32'd0);
    chk("init_res",   32'(res),       32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known word 0ABC on channel 3 (command 1800).
    mem[3] = 12'hABC;
    nib    = 4'h0;
    run_conv(3, -1, 0, -1);

    // Every channel against random model memory and random upper nibbles.
    for (int ch = 0; ch < 8; ch++) begin
      mem[ch] = 12'($urandom);
      nib     = 4'($urandom);
      run_conv(ch, -1, 0, -1);
    end

    // Second start while busy must be ignored.
    mem[5] = 12'($urandom);
    run_conv(5, 300, 2, -1);

    // Upper nibble of the returned word is dropped.
    mem[6] = 12'h123;
    nib    = 4'hF;
    run_conv(6, -1, 0, -1);

    // Reset mid-conversion, then a clean conversion.
    run_conv(4, -1, 0, 700);
    mem[1] = 12'($urandom);
    nib    = 4'($urandom);
    run_conv(1, -1, 0, -1);

    for (int k = 0; k < 3; k++) begin
      int ch;
      ch      = $urandom_range(0, 7);
      mem[ch] = 12'($urandom);
      nib     = 4'($urandom);
      run_conv(ch, -1, 0, -1);
    end

    chk("sclk_edge_ss_high", 32'(edge_hi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
